// File: rtl/qspi_flash_responder_if.sv
// Quad-SPI flash pins between an XIP controller (master) and the flash responder (slave).
interface qspi_flash_responder_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic       douten;

  modport master (output sck, ce_n, din, input dout, douten);
  modport slave  (input sck, ce_n, din, output dout, douten);
endinterface

// File: rtl/qspi_flash_responder.sv
// QSPI NOR-flash responder: EBh quad fast read with continuous-read mode and the 66h/99h
// reset pair. All pins are sampled in the clk domain; sck edges are detected, never used as clocks.
module qspi_flash_responder #(
  parameter int MEM_BYTES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  qspi_flash_responder_if.slave        bus,
  input  logic                         prog_we,
  input  logic [$clog2(MEM_BYTES)-1:0] prog_addr,
  input  logic [7:0]                   prog_data,
  output logic                         cont_mode,
  output logic                         sw_reset
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_WAIT
  } state_t;

  state_t        state, state_next;
  logic          sck_q, ce_q;
  logic          rise, fall, ce_fall, frame_end;
  logic [2:0]    cnt;
  logic [7:0]    cmd, cmd_shift;
  logic          over;        // rise seen after the 8 command bits
  logic [AW-1:0] addr;
  logic          nib_lo;
  logic          mode_keep, mode_done, from_addr, rst_en;
  logic [7:0]    rd_byte;
  logic [7:0]    mem [MEM_BYTES];

  // NOTE: the array has no reset so preloaded contents survive rst and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  assign rd_byte   = mem[addr];
  assign rise      = bus.sck & ~sck_q & ~bus.ce_n;
  assign fall      = ~bus.sck & sck_q & ~bus.ce_n;
  assign ce_fall   = ce_q & ~bus.ce_n;
  assign frame_end = bus.ce_n & (state != S_IDLE);
  assign cmd_shift = {cmd[6:0], bus.din[0]};

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (bus.ce_n) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (ce_fall) state_next = cont_mode ? S_ADDR : S_CMD;
        S_CMD:   if (rise && cnt == 3'd7) state_next = (cmd_shift == 8'hEB) ? S_ADDR : S_WAIT;
        S_ADDR:  if (rise && cnt == 3'd5) state_next = S_MODE;
        S_MODE:  if (rise && cnt == 3'd1) state_next = S_DUMMY;
        S_DUMMY: if (fall && cnt == 3'd4) state_next = S_DATA;
        default: state_next = state;
      endcase
    end
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sck_q      <= 1'b0;
      ce_q       <= 1'b0;   // a frame already in progress is not joined mid-way
      cnt        <= '0;
      cmd        <= '0;
      over       <= 1'b0;
      addr       <= '0;
      nib_lo     <= 1'b0;
      mode_keep  <= 1'b0;
      mode_done  <= 1'b0;
      from_addr  <= 1'b0;
      rst_en     <= 1'b0;
      cont_mode  <= 1'b0;
      sw_reset   <= 1'b0;
      bus.dout   <= '0;
      bus.douten <= 1'b0;
    end else begin
      state    <= state_next;
      sck_q    <= bus.sck;
      ce_q     <= bus.ce_n;
      sw_reset <= 1'b0;

      if (frame_end) begin
        bus.dout   <= '0;
        bus.douten <= 1'b0;
        cnt        <= '0;
        if (state == S_WAIT && !over && cmd == 8'h99 && rst_en) begin
          cont_mode <= 1'b0;
          rst_en    <= 1'b0;
          sw_reset  <= 1'b1;
        end else begin
          rst_en <= (state == S_WAIT) && !over && (cmd == 8'h66);
          if (mode_done)      cont_mode <= mode_keep;
          else if (from_addr) cont_mode <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: if (ce_fall) begin
            cnt       <= '0;
            over      <= 1'b0;
            nib_lo    <= 1'b0;
            mode_keep <= 1'b0;
            mode_done <= 1'b0;
            from_addr <= cont_mode;
          end
          S_CMD: if (rise) begin
            cmd <= cmd_shift;
            cnt <= cnt + 3'd1;
          end
          S_ADDR: if (rise) begin
            addr <= {addr[AW-5:0], bus.din};
            cnt  <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
          end
          S_MODE: if (rise) begin
            if (cnt == 3'd0) mode_keep <= (bus.din == 4'hA);
            else             mode_done <= 1'b1;
            cnt <= (cnt == 3'd1) ? 3'd0 : cnt + 3'd1;
          end
          S_DUMMY: begin
            if (rise && cnt != 3'd4) cnt <= cnt + 3'd1;
            if (fall && cnt == 3'd4) begin
              bus.dout   <= rd_byte[7:4];
              bus.douten <= 1'b1;
              nib_lo     <= 1'b1;
            end
          end
          S_DATA: if (fall) begin
            if (nib_lo) begin
              bus.dout <= rd_byte[3:0];
              addr     <= addr + ADDR_ONE;
              nib_lo   <= 1'b0;
            end else begin
              bus.dout <= rd_byte[7:4];
              nib_lo   <= 1'b1;
            end
          end
          S_WAIT: if (rise) over <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qspi_flash_responder.sv
// Self-checking bench for qspi_flash_responder: table-driven reads, reset-pair and rst
// sequences, then randomized frames against a byte-array reference model.
module tb_qspi_flash_responder;
  localparam int MEM_BYTES = 1024;
  localparam int AW = $clog2(MEM_BYTES);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [7:0]    prog_data = '0;
  logic          cont_mode, sw_reset;

  qspi_flash_responder_if bus();

  qspi_flash_responder #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cont_mode (cont_mode),
    .sw_reset  (sw_reset)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         sw_count = 0;
  logic [7:0] ref_mem [MEM_BYTES];
  logic [3:0] rx_nib [64];
  int         lo_len = 1, hi_len = 1;
  logic       oe_pre, oe_data, oe_after;
  logic [1:0] sw_pair;
  bit         m_cont;

  typedef struct {
    bit             use_cmd;
    logic [23:0]    addr;
    logic [7:0]     mode;
    int             nbytes;
    logic [3:0][7:0] exp;    // exp[3] is the first byte read
    bit             exp_cont;
  } vec_t;
  vec_t tbl [6];

  always @(negedge clk) if (sw_reset) sw_count++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [23:0] a, input int k);
    return ref_mem[(int'(a) + k) % MEM_BYTES];
  endfunction

  task automatic pulse(input logic [3:0] d, output logic [3:0] q, output logic oe);
    bus.din = d;
    repeat (lo_len) @(negedge clk);
    bus.sck = 1'b1;
    repeat (hi_len) @(negedge clk);
    q  = bus.dout;
    oe = bus.douten;
    bus.sck = 1'b0;
  endtask

  task automatic start_frame();
    bus.ce_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_frame();
    bus.ce_n = 1'b1;
    @(negedge clk);
    oe_after   = bus.douten;
    sw_pair[1] = sw_reset;
    @(negedge clk);
    sw_pair[0] = sw_reset;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int extra);
    logic [3:0] q;
    logic       oe;
    for (int i = 7; i >= 0; i--) begin
      pulse({3'b000, b[i]}, q, oe);
      oe_pre |= oe;
    end
    for (int i = 0; i < extra; i++) begin
      pulse(4'h0, q, oe);
      oe_pre |= oe;
    end
  endtask

  task automatic cmd_frame(input logic [7:0] b, input int extra);
    oe_pre = 1'b0;
    start_frame();
    send_byte(b, extra);
    end_frame();
  endtask

  task automatic read_frame(input bit use_cmd, input logic [23:0] a, input logic [7:0] mode,
                            input int nbytes);
    logic [3:0] q;
    logic       oe;
    oe_pre  = 1'b0;
    oe_data = 1'b1;
    start_frame();
    if (use_cmd) send_byte(8'hEB, 0);
    for (int i = 5; i >= 0; i--) begin
      pulse(a[i*4 +: 4], q, oe);
      oe_pre |= oe;
    end
    pulse(mode[7:4], q, oe); oe_pre |= oe;
    pulse(mode[3:0], q, oe); oe_pre |= oe;
    for (int i = 0; i < 4; i++) begin
      pulse(4'($urandom), q, oe);
      oe_pre |= oe;
    end
    for (int k = 0; k < 2 * nbytes; k++) begin
      pulse(4'($urandom), rx_nib[k], oe);
      oe_data &= oe;
    end
    end_frame();
  endtask

  task automatic check_read(input string tag, input logic [23:0] a, input int nbytes,
                            input bit exp_cont);
    for (int k = 0; k < nbytes; k++)
      check($sformatf("%s_byte%0d", tag, k), {rx_nib[2*k], rx_nib[2*k+1]}, model_byte(a, k));
    check({tag, "_douten_pre"},  oe_pre,   1'b0);
    check({tag, "_douten_data"}, oe_data,  1'b1);
    check({tag, "_douten_end"},  oe_after, 1'b0);
    check({tag, "_cont"},        cont_mode, exp_cont);
  endtask

  task automatic write_byte(input int idx, input logic [7:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = AW'(idx);
    prog_data = d;
    ref_mem[idx] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  initial begin
    logic [3:0]  q;
    logic        oe;
    logic        oe_any;
    logic [23:0] a;
    logic [7:0]  mode;
    int          n;

    bus.sck  = 1'b0;
    bus.ce_n = 1'b1;
    bus.din  = 4'h0;

    tbl[0] = '{1'b1, 24'h000000, 8'hA5, 16, 32'h10111213, 1'b1};
    tbl[1] = '{1'b0, 24'h000008, 8'hA5, 2,  32'h18190000, 1'b1};
    tbl[2] = '{1'b0, 24'h000002, 8'h00, 2,  32'h12130000, 1'b0};
    tbl[3] = '{1'b1, 24'h000004, 8'h5A, 3,  32'h14151600, 1'b0};
    tbl[4] = '{1'b1, 24'h0003FE, 8'hAF, 4,  32'hF5FC1011, 1'b1};
    tbl[5] = '{1'b0, 24'hABC40F, 8'h0F, 3,  32'h1F737A00, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_dout",      bus.dout,   4'h0);
    check("rst_douten",    bus.douten, 1'b0);
    check("rst_cont_mode", cont_mode,  1'b0);
    check("rst_sw_reset",  sw_reset,   1'b0);
    rst = 1'b0;

    // Preload: 00..0F hold 10h..1Fh, the rest a simple arithmetic pattern.
    prog_we = 1'b1;
    for (int i = 0; i < MEM_BYTES; i++) begin
      prog_addr = AW'(i);
      prog_data = (i < 16) ? 8'(8'h10 + i) : 8'((i * 7 + 3) & 255);
      ref_mem[i] = prog_data;
      @(negedge clk);
    end
    prog_we = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      read_frame(tbl[t].use_cmd, tbl[t].addr, tbl[t].mode, tbl[t].nbytes);
      for (int k = 0; k < tbl[t].nbytes; k++)
        check($sformatf("tbl%0d_byte%0d", t, k), {rx_nib[2*k], rx_nib[2*k+1]},
              (k < 4) ? tbl[t].exp[3-k] : model_byte(tbl[t].addr, k));
      check($sformatf("tbl%0d_douten_pre", t),  oe_pre,    1'b0);
      check($sformatf("tbl%0d_douten_data", t), oe_data,   1'b1);
      check($sformatf("tbl%0d_douten_end", t),  oe_after,  1'b0);
      check($sformatf("tbl%0d_cont", t),        cont_mode, tbl[t].exp_cont);
    end

    // Reset pair, starting from continuous mode: the first 66h on IO0 lands in ADDR/MODE.
    read_frame(1'b1, 24'h000000, 8'hA0, 1);
    check_read("pair_setup", 24'h000000, 1, 1'b1);
    cmd_frame(8'h66, 0);
    check("pair_cont_exit", cont_mode, 1'b0);
    check("pair_sw_a",      sw_pair,   2'b00);
    cmd_frame(8'h99, 0);
    check("pair_sw_b",      sw_pair,   2'b00);
    cmd_frame(8'h66, 1);
    cmd_frame(8'h99, 0);
    check("pair_sw_long66", sw_pair,   2'b00);
    check("pair_oe_cmd",    oe_pre,    1'b0);
    cmd_frame(8'h66, 0);
    check("pair_sw_c",      sw_pair,   2'b00);
    cmd_frame(8'h99, 0);
    check("pair_sw_pulse",  sw_pair,   2'b10);
    check("pair_cont_end",  cont_mode, 1'b0);
    read_frame(1'b1, 24'h000005, 8'h00, 2);
    check("pair_read_b0", {rx_nib[0], rx_nib[1]}, 8'h15);
    check("pair_read_b1", {rx_nib[2], rx_nib[3]}, 8'h16);

    // rst in the DATA phase of a continuous frame.
    read_frame(1'b1, 24'h000000, 8'hA5, 1);
    check("rstd_setup_cont", cont_mode, 1'b1);
    start_frame();
    for (int i = 0; i < 6; i++) pulse(4'h0, q, oe);
    pulse(4'hA, q, oe);
    pulse(4'h5, q, oe);
    for (int i = 0; i < 4; i++) pulse(4'h0, q, oe);
    pulse(4'h0, rx_nib[0], oe);
    pulse(4'h0, rx_nib[1], oe);
    check("rstd_pre_byte", {rx_nib[0], rx_nib[1]}, 8'h10);
    check("rstd_pre_oe",   oe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rstd_douten", bus.douten, 1'b0);
    check("rstd_dout",   bus.dout,   4'h0);
    check("rstd_cont",   cont_mode,  1'b0);
    rst = 1'b0;
    oe_any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pulse(4'hF, q, oe);
      oe_any |= oe | (q != 4'h0);
    end
    check("rstd_ignored", oe_any, 1'b0);
    end_frame();
    read_frame(1'b1, 24'h0003FF, 8'h00, 2);
    check("rstd_after_b0", {rx_nib[0], rx_nib[1]}, 8'hFC);
    check("rstd_after_b1", {rx_nib[2], rx_nib[3]}, 8'h10);
    m_cont = 1'b0;

    // Randomized frames with preload writes, varied sck phase lengths.
    for (int f = 0; f < 24; f++) begin
      lo_len = $urandom_range(1, 3);
      hi_len = $urandom_range(1, 3);
      a      = 24'($urandom);
      n      = $urandom_range(1, 6);
      mode   = $urandom_range(0, 1) ? {4'hA, 4'($urandom)} : 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3))
          write_byte((int'(a) + $urandom_range(0, n - 1)) % MEM_BYTES, 8'($urandom));
      end
      read_frame(!m_cont, a, mode, n);
      m_cont = (mode[7:4] == 4'hA);
      check_read($sformatf("rnd%0d", f), a, n, m_cont);
    end

    check("sw_reset_total", sw_count, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
